// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and dispatch: up to N enqueues and
// N in-order dequeues per cycle, single-cycle flush on mispredict.

module inst_buffer_lane #(
  parameter int LANE = 0,
  parameter int W    = 97,
  parameter int NSB  = 2
) (
  input  logic [W-1:0]   entry,
  input  logic [NSB-1:0] valid_cnt,
  output logic [W-1:0]   packet
);
  // Slots past the valid window drive zero so dispatch never latches stale data.
  assign packet = (NSB'(LANE) < valid_cnt) ? entry : '0;
endmodule

module inst_buffer #(
  parameter int N               = 3,
  parameter int IB_SZ           = 16,
  parameter int CNT_BITS        = $clog2(IB_SZ+1),
  parameter int NUM_SCALAR_BITS = $clog2(N+1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N-1:0]                      fetch_valid,
  input  logic [N-1:0][31:0]                fetch_inst,
  input  logic [N-1:0][31:0]                fetch_pc,
  input  logic [N-1:0]                      fetch_pred_taken,
  input  logic [N-1:0][31:0]                fetch_pred_npc,
  output logic [NUM_SCALAR_BITS-1:0]        ib_spots,
  input  logic                              flush,
  input  logic [NUM_SCALAR_BITS-1:0]        num_dispatched,
  output logic [N-1:0][96:0]                instruction_packets,
  output logic [NUM_SCALAR_BITS-1:0]        instructions_valid,
  output logic [CNT_BITS-1:0]               ib_count
);
  localparam int PTR_W = $clog2(IB_SZ);
  localparam int ENT_W = 97;
  localparam int NSB   = NUM_SCALAR_BITS;

  logic [ENT_W-1:0]    ent [IB_SZ];
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_BITS-1:0] count, free;
  logic [NSB-1:0]      offer, enq, deq;
  logic [PTR_W-1:0]    wr_idx [N];

  always_comb begin
    offer = '0;
    for (int k = 0; k < N; k++) offer = offer + NSB'(fetch_valid[k]);
    free               = CNT_BITS'(IB_SZ) - count;
    ib_spots           = (free > CNT_BITS'(N)) ? NSB'(N) : free[NSB-1:0];
    instructions_valid = (count > CNT_BITS'(N)) ? NSB'(N) : count[NSB-1:0];
    // Over-offers and over-dispatches are clipped rather than trusted.
    enq = (offer > ib_spots) ? ib_spots : offer;
    deq = (num_dispatched > instructions_valid) ? instructions_valid : num_dispatched;
    for (int k = 0; k < N; k++) wr_idx[k] = tail + PTR_W'(k);
  end

  assign ib_count = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq);
      tail  <= tail + PTR_W'(enq);
      count <= count + CNT_BITS'(enq) - CNT_BITS'(deq);
    end
  end

  // Entry storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clock) begin
    for (int k = 0; k < N; k++)
      if (reset && !flush && (NSB'(k) < enq))
        ent[wr_idx[k]] <= {fetch_inst[k], fetch_pc[k], fetch_pred_taken[k], fetch_pred_npc[k]};
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx = head + PTR_W'(i);
    inst_buffer_lane #(.LANE(i), .W(ENT_W), .NSB(NSB)) u_lane (
      .entry     (ent[rd_idx]),
      .valid_cnt (instructions_valid),
      .packet    (instruction_packets[i])
    );
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: expected PCs queued at enqueue, compared at dispatch.

module tb_inst_buffer;
  localparam int N = 3;
  localparam int IB_SZ = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      fetch_valid = '0;
  logic [N-1:0][31:0] fetch_inst = '0;
  logic [N-1:0][31:0] fetch_pc = '0;
  logic [N-1:0]      fetch_pred_taken = '0;
  logic [N-1:0][31:0] fetch_pred_npc = '0;
  logic [1:0]        ib_spots;
  logic              flush = 1'b0;
  logic [1:0]        num_dispatched = '0;
  logic [N-1:0][96:0] instruction_packets;
  logic [1:0]        instructions_valid;
  logic [4:0]        ib_count;

  int checks = 0;
  int failures = 0;
  int cnt = 0;
  logic [31:0] q[$];
  logic [31:0] got[$];

  always #5 clock = ~clock;

  inst_buffer dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .fetch_pred_taken(fetch_pred_taken), .fetch_pred_npc(fetch_pred_npc),
    .ib_spots(ib_spots), .flush(flush), .num_dispatched(num_dispatched),
    .instruction_packets(instruction_packets), .instructions_valid(instructions_valid),
    .ib_count(ib_count)
  );

  function automatic logic [96:0] pkt(input logic [31:0] pc);
    return {~pc, pc, pc[2], pc + 32'd4};
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string tag, input logic [96:0] obs, input logic [96:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    checks++;
    assert (ib_count <= 5'(IB_SZ)) else begin
      failures++;
      $error("FAIL occupancy_bound observed=%0d expected<=%0d", ib_count, IB_SZ);
    end
  end

  // Drive one cycle, check presented state against the model, then advance.
  task automatic cycle(input int nv, input logic [31:0] base, input int nd, input bit fl);
    int iv, sp, acc, dq;
    for (int k = 0; k < N; k++) begin
      fetch_valid[k]      = (k < nv);
      fetch_pc[k]         = (k < nv) ? base + 32'(4*k) : '0;
      fetch_inst[k]       = ~fetch_pc[k];
      fetch_pred_taken[k] = fetch_pc[k][2];
      fetch_pred_npc[k]   = fetch_pc[k] + 32'd4;
    end
    num_dispatched = 2'(nd);
    flush = fl;
    iv = min2(cnt, N);
    sp = min2(IB_SZ - cnt, N);
    check("ib_count", 97'(ib_count), 97'(cnt));
    check("instructions_valid", 97'(instructions_valid), 97'(iv));
    check("ib_spots", 97'(ib_spots), 97'(sp));
    for (int j = 0; j < N; j++)
      check($sformatf("slot%0d", j), instruction_packets[j], (j < iv) ? pkt(q[j]) : '0);
    if (fl) begin
      q.delete();
      cnt = 0;
    end else begin
      acc = min2(nv, sp);
      dq  = min2(nd, iv);
      for (int d = 0; d < dq; d++) got.push_back(q.pop_front());
      for (int k = 0; k < acc; k++) q.push_back(base + 32'(4*k));
      cnt = cnt + acc - dq;
    end
    @(posedge clock); #1;
    fetch_valid = '0;
    num_dispatched = '0;
    flush = 1'b0;
  endtask

  initial begin
    int sent, nv, nd, guard;
    // Reset held for two edges, then released
    repeat (2) @(posedge clock);
    #1;
    check("rst_ivalid", 97'(instructions_valid), 97'd0);
    check("rst_spots", 97'(ib_spots), 97'd3);
    check("rst_count", 97'(ib_count), 97'd0);
    check("rst_pkts", 97'(instruction_packets[0] | instruction_packets[1] | instruction_packets[2]), 97'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Single enqueue / dequeue
    cycle(3, 32'h0, 0, 0);
    check("t1_ivalid", 97'(instructions_valid), 97'd3);
    check("t1_pc0", 97'(instruction_packets[0][64:33]), 97'h0);
    cycle(0, 32'h0, 2, 0);
    check("t2_ivalid", 97'(instructions_valid), 97'd1);
    check("t2_pc0", 97'(instruction_packets[0][64:33]), 97'h8);
    cycle(0, 32'h0, 1, 0);

    // Fill to full; sixth offer takes only one
    for (int i = 0; i < 6; i++) cycle(3, 32'h100 + 32'(12*i), 0, 0);
    check("full_count", 97'(ib_count), 97'd16);
    check("full_spots", 97'(ib_spots), 97'd0);
    check("full_last_pc", 97'(q[15]), 97'h13C);
    cycle(3, 32'h200, 3, 0);
    check("drain_count", 97'(ib_count), 97'd13);
    guard = 0;
    while (cnt > 0 && guard < 20) begin cycle(0, 32'h0, 3, 0); guard++; end

    // Randomized wrap-around stream of 40 sequential PCs
    got.delete();
    sent = 0;
    guard = 0;
    while ((sent < 40 || cnt > 0) && guard < 400) begin
      nv = $urandom_range(0, min2(min2(IB_SZ - cnt, N), 40 - sent));
      nd = $urandom_range(0, min2(cnt, N));
      cycle(nv, 32'(sent*4), nd, 0);
      sent += nv;
      guard++;
    end
    check("wrap_total", 97'(got.size()), 97'd40);
    for (int i = 0; i < got.size(); i++)
      if (i < 40) check($sformatf("wrap_order%0d", i), 97'(got[i]), 97'(i*4));

    // Flush with concurrent enqueue and dispatch
    cycle(3, 32'h300, 0, 0);
    cycle(3, 32'h30C, 0, 0);
    cycle(3, 32'h318, 0, 0);
    cycle(1, 32'h324, 0, 0);
    check("pre_flush_count", 97'(ib_count), 97'd10);
    cycle(3, 32'h400, 2, 1);
    check("flush_count", 97'(ib_count), 97'd0);
    check("flush_ivalid", 97'(instructions_valid), 97'd0);
    check("flush_spots", 97'(ib_spots), 97'd3);
    cycle(1, 32'h500, 0, 0);
    check("post_flush_pc0", 97'(instruction_packets[0][64:33]), 97'h500);
    cycle(0, 32'h0, 1, 0);

    // Asynchronous reset between edges
    cycle(3, 32'h600, 0, 0);
    cycle(3, 32'h60C, 0, 0);
    cycle(1, 32'h618, 0, 0);
    check("pre_arst_count", 97'(ib_count), 97'd7);
    #2 reset = 1'b0;
    #1;
    check("arst_count", 97'(ib_count), 97'd0);
    check("arst_ivalid", 97'(instructions_valid), 97'd0);
    check("arst_pkt0", instruction_packets[0], 97'd0);
    q.delete();
    cnt = 0;
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    cycle(0, 32'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
